// File: rtl/demux5b16_wb.sv
// demux5b16_wb: write-back distributor for the 16-bit relPrime datapath.
// A small in-order FIFO of {selector, data} feeds five destination holding
// registers (A..E), each with its own valid/ack handshake. Illegal
// selectors (5..7) are dropped and flagged on the sticky sel_err output.
// Optional feature macro: DEMUX5B16_ERR_CNT_EN adds a saturating 8-bit
// count of dropped illegal-selector entries on err_cnt.
module demux5b16_wb #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 16
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic [2:0]       in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] A_out,
  output logic [WIDTH-1:0] B_out,
  output logic [WIDTH-1:0] C_out,
  output logic [WIDTH-1:0] D_out,
  output logic [WIDTH-1:0] E_out,
  output logic [4:0]       out_valid,
  input  logic [4:0]       out_ack,
  output logic             sel_err,
`ifdef DEMUX5B16_ERR_CNT_EN
  output logic [7:0]       err_cnt,
`endif
  output logic             busy
);

  localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW    = PW + 1;
  localparam int unsigned NDEST = 5;

  // FIFO storage and pointers
  logic [WIDTH-1:0] data_mem [DEPTH];
  logic [2:0]       sel_mem  [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  // destination holding registers
  logic [WIDTH-1:0] dest_q [NDEST];

  // next-state / control terms
  logic             enq;
  logic             deq;
  logic             deq_legal;
  logic             deq_illegal;
  logic             head_legal;
  logic             head_free;
  logic [2:0]       head_sel;
  logic [WIDTH-1:0] head_data;
  logic [4:0]       load;
  logic [4:0]       valid_nxt;
  logic [CW-1:0]    count_nxt;

  assign head_sel  = sel_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];

  // Dispatch decision on the FIFO head and next-state computation
  always_comb begin
    enq         = in_valid & in_ready;
    head_legal  = (head_sel < 3'd5);
    head_free   = 1'b0;
    load        = '0;
    for (int i = 0; i < int'(NDEST); i++) begin
      if (head_sel == 3'(i)) begin
        head_free = ~out_valid[i] | out_ack[i];
      end
    end
    deq_legal   = (count != '0) & head_legal & head_free;
    deq_illegal = (count != '0) & ~head_legal;
    deq         = deq_legal | deq_illegal;
    for (int i = 0; i < int'(NDEST); i++) begin
      load[i] = deq_legal & (head_sel == 3'(i));
    end
    // an ack frees the slot unless the same cycle refills it
    valid_nxt   = (out_valid & ~out_ack) | load;
    count_nxt   = count + CW'(enq) - CW'(deq);
  end

  // FIFO write port; contents are only ever read while count is non-zero
  always_ff @(posedge CLK) begin
    if (enq) begin
      data_mem[wr_ptr] <= in_data;
      sel_mem[wr_ptr]  <= in_sel;
    end
  end

  // Control state: pointers, occupancy, handshake flags and status
  always_ff @(posedge CLK) begin
    if (Reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= '0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      sel_err   <= 1'b0;
    end else begin
      if (enq) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (deq) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count     <= count_nxt;
      out_valid <= valid_nxt;
      // in_ready and busy track the registered occupancy one-for-one
      in_ready  <= (count_nxt < CW'(DEPTH));
      busy      <= (count_nxt != '0) | (|valid_nxt);
      if (deq_illegal) begin
        sel_err <= 1'b1;
      end
    end
  end

  // Destination holding registers load on a legal dequeue to that slot
  always_ff @(posedge CLK) begin
    for (int i = 0; i < int'(NDEST); i++) begin
      if (Reset) begin
        dest_q[i] <= '0;
      end else if (load[i]) begin
        dest_q[i] <= head_data;
      end
    end
  end

  assign A_out = dest_q[0];
  assign B_out = dest_q[1];
  assign C_out = dest_q[2];
  assign D_out = dest_q[3];
  assign E_out = dest_q[4];

`ifdef DEMUX5B16_ERR_CNT_EN
  // Saturating count of dropped illegal-selector entries
  always_ff @(posedge CLK) begin
    if (Reset) begin
      err_cnt <= 8'd0;
    end else if (deq_illegal && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule
